// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone burst RAM slave.
//   wb_state_e    : slave FSM state encodings (also exported on the debug port)
//   CTI_*         : Wishbone cycle type identifiers
//   BTE_*         : Wishbone burst type extensions
//   bte_wrap_mask : low-index mask of the wrap block selected by a BTE code
package wb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_XFER  = 3'd2,
        ST_BURST = 3'd3,
        ST_DONE  = 3'd4
    } wb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    // Index bits that roll over inside a wrapping burst; 0 means linear.
    function automatic logic [3:0] bte_wrap_mask(input logic [1:0] bte);
        logic [3:0] mask;
        case (bte)
            BTE_WRAP4:  mask = 4'h3;
            BTE_WRAP8:  mask = 4'h7;
            BTE_WRAP16: mask = 4'hF;
            default:    mask = 4'h0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/wb_ram_core.sv
// DEPTH x DATA_W synchronous RAM, one byte-wide memory per lane so each lane
// maps onto its own block RAM with a plain write enable.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset of the read register only
//   wr_en   : write strobe, qualified per lane by wr_sel
//   wr_sel  : byte-lane enables
//   wr_addr : write word index
//   wr_data : write data
//   rd_addr : read word index, data appears on rd_data one cycle later
//   rd_data : registered read data
module wb_ram_core #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    localparam int AW    = $clog2(DEPTH),
    localparam int LANES = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [LANES-1:0]  wr_sel,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_reg;

            always_ff @(posedge clk) begin
                if (wr_en && wr_sel[gi]) begin
                    mem[wr_addr] <= wr_data[gi*8 +: 8];
                end
            end

            // Reset clears only the output register; contents survive reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_reg <= '0;
                end else begin
                    rd_reg <= mem[rd_addr];
                end
            end

            assign rd_data[gi*8 +: 8] = rd_reg;
        end
    endgenerate

endmodule

// File: rtl/wb_burst_ram_slave.sv
// Wishbone B4 registered-feedback RAM slave with classic and incrementing
// burst (linear / wrap4 / wrap8 / wrap16) support and optional wait states.
// Ports:
//   CLK100MHZ : clock, all logic on the rising edge
//   rst       : synchronous active-high reset
//   s_addr    : byte address          s_idata : write data
//   s_odata   : read data (zero unless acked)
//   s_sel     : byte enables          s_we    : 1 = write
//   s_cyc     : bus cycle             s_stb   : strobe
//   s_cti     : cycle type            s_bte   : burst type
//   s_ack     : transfer acknowledge  s_err   : error terminate
//   s_rty     : retry (always 0)      st      : current state code
module wb_burst_ram_slave
    import wb_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                CLK100MHZ,
    input  logic                rst,
    input  logic [31:0]         s_addr,
    input  logic [DATA_W-1:0]   s_idata,
    output logic [DATA_W-1:0]   s_odata,
    input  logic [DATA_W/8-1:0] s_sel,
    input  logic                s_we,
    input  logic                s_cyc,
    input  logic                s_stb,
    input  logic [2:0]          s_cti,
    input  logic [1:0]          s_bte,
    output logic                s_ack,
    output logic                s_err,
    output logic                s_rty,
    output logic [7:0]          st
);

    localparam int          LANES     = DATA_W / 8;
    localparam int          AW        = $clog2(DEPTH);
    localparam int          LB        = $clog2(LANES);
    localparam logic [32:0] WIN_BYTES = 33'(DEPTH) * 33'(LANES);
    localparam logic [3:0]  WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    wb_state_e     state_reg, state_next;
    logic [AW-1:0] idx_reg, idx_next;
    logic [3:0]    wait_cnt_reg, wait_cnt_next;
    logic [1:0]    bte_reg, bte_next;
    logic          burst_reg, burst_next;   // accepted cycle was an incrementing burst
    logic          bad_reg, bad_next;       // accepted address was outside the window
    logic          beyond_reg, beyond_next; // linear burst has stepped past the last word

    logic [31:0]       offset;
    logic              in_range;
    logic [AW-1:0]     addr_idx;
    logic [AW-1:0]     wrap_mask;
    logic [AW-1:0]     step_idx;
    logic [AW-1:0]     rd_idx;
    logic              ack;
    logic              err;
    logic              wr_en;
    logic [DATA_W-1:0] rd_data;

    assign offset   = s_addr - BASE_ADDR;
    // Addresses below the base wrap to huge offsets and fail this test too.
    assign in_range = {1'b0, offset} < WIN_BYTES;
    assign addr_idx = offset[LB +: AW];

    assign wrap_mask = AW'(bte_wrap_mask(bte_reg));
    assign step_idx  = (bte_reg == BTE_LINEAR)
                     ? idx_reg + AW'(1)
                     : (idx_reg & ~wrap_mask) | ((idx_reg + AW'(1)) & wrap_mask);

    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            wait_cnt_reg <= '0;
            bte_reg      <= BTE_LINEAR;
            burst_reg    <= 1'b0;
            bad_reg      <= 1'b0;
            beyond_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            wait_cnt_reg <= wait_cnt_next;
            bte_reg      <= bte_next;
            burst_reg    <= burst_next;
            bad_reg      <= bad_next;
            beyond_reg   <= beyond_next;
        end
    end

    // The RAM read is issued one cycle ahead of the ack that presents it:
    // in IDLE from the live address, afterwards from the latched index, and
    // in BURST from the stepped index whenever the current beat is acked.
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        wait_cnt_next = wait_cnt_reg;
        bte_next      = bte_reg;
        burst_next    = burst_reg;
        bad_next      = bad_reg;
        beyond_next   = beyond_reg;
        rd_idx        = idx_reg;
        ack           = 1'b0;
        err           = 1'b0;
        wr_en         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                rd_idx = addr_idx;
                if (s_cyc && s_stb) begin
                    idx_next      = addr_idx;
                    bte_next      = s_bte;
                    burst_next    = (s_cti == CTI_INCR);
                    bad_next      = !in_range;
                    beyond_next   = 1'b0;
                    wait_cnt_next = '0;
                    if (WAIT_STATES > 0) begin
                        state_next = ST_WAIT;
                    end else if (in_range && s_cti == CTI_INCR) begin
                        state_next = ST_BURST;
                    end else begin
                        state_next = ST_XFER;
                    end
                end
            end

            ST_WAIT: begin
                if (!s_stb) begin
                    state_next = ST_IDLE;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    state_next = (burst_reg && !bad_reg) ? ST_BURST : ST_XFER;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
            end

            ST_XFER: begin
                if (s_stb) begin
                    if (bad_reg) begin
                        err = 1'b1;
                    end else begin
                        ack   = 1'b1;
                        wr_en = s_we;
                    end
                    state_next = ST_DONE;
                end
            end

            ST_BURST: begin
                if (s_stb) begin
                    if (beyond_reg) begin
                        err        = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        ack      = 1'b1;
                        wr_en    = s_we;
                        idx_next = step_idx;
                        rd_idx   = step_idx;
                        if (bte_reg == BTE_LINEAR && idx_reg == '1) begin
                            beyond_next = 1'b1;
                        end
                        if (s_cti == CTI_EOB) begin
                            state_next = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Losing the cycle aborts whatever is in flight.
        if (!s_cyc) begin
            state_next = ST_IDLE;
            ack        = 1'b0;
            err        = 1'b0;
            wr_en      = 1'b0;
        end
    end

    // Gating with rst keeps a beat presented during reset from being
    // acknowledged or written.
    assign s_ack   = ack & ~rst;
    assign s_err   = err & ~rst;
    assign s_rty   = 1'b0;
    assign s_odata = s_ack ? rd_data : '0;
    assign st      = {5'd0, state_reg};

    wb_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (CLK100MHZ),
        .rst     (rst),
        .wr_en   (wr_en & ~rst),
        .wr_sel  (s_sel),
        .wr_addr (idx_reg),
        .wr_data (s_idata),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_wb_burst_ram_slave.sv
// Self-checking bench for wb_burst_ram_slave: one zero-wait instance and one
// three-wait-state instance sharing the bus inputs; read data is checked
// through a scoreboard queue filled from a bench-side memory model.
module tb_wb_burst_ram_slave;
    import wb_pkg::*;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE3 = 32'h0000_0400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] idata = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [2:0]  cti = CTI_CLASSIC;
    logic [1:0]  bte = BTE_LINEAR;
    logic        use3 = 1'b0;

    logic [31:0] odata0, odata3;
    logic        ack0, ack3, err0, err3, rty0, rty3;
    logic [7:0]  st0, st3;
    logic        cyc0, cyc3, stb0, stb3;
    logic        ack_m, err_m;
    logic [31:0] odata_m;
    logic [7:0]  st_m;

    assign cyc0    = cyc & ~use3;
    assign stb0    = stb & ~use3;
    assign cyc3    = cyc & use3;
    assign stb3    = stb & use3;
    assign ack_m   = use3 ? ack3 : ack0;
    assign err_m   = use3 ? err3 : err0;
    assign odata_m = use3 ? odata3 : odata0;
    assign st_m    = use3 ? st3 : st0;

    wb_burst_ram_slave #(
        .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(0)
    ) dut0 (
        .CLK100MHZ(clk), .rst(rst), .s_addr(addr), .s_idata(idata), .s_odata(odata0),
        .s_sel(sel), .s_we(we), .s_cyc(cyc0), .s_stb(stb0), .s_cti(cti), .s_bte(bte),
        .s_ack(ack0), .s_err(err0), .s_rty(rty0), .st(st0)
    );

    wb_burst_ram_slave #(
        .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE3), .WAIT_STATES(3)
    ) dut3 (
        .CLK100MHZ(clk), .rst(rst), .s_addr(addr), .s_idata(idata), .s_odata(odata3),
        .s_sel(sel), .s_we(we), .s_cyc(cyc3), .s_stb(stb3), .s_cti(cti), .s_bte(bte),
        .s_ack(ack3), .s_err(err3), .s_rty(rty3), .st(st3)
    );

    int          checks_total = 0;
    int          checks_passed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model0 [DEPTH];
    logic [31:0] model3 [DEPTH];
    bit          first_ack;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic model_wr(input int w, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) begin
                if (use3) model3[w][b*8 +: 8] = d[b*8 +: 8];
                else      model0[w][b*8 +: 8] = d[b*8 +: 8];
            end
        end
    endtask

    function automatic int beat_word(input int start, input int blk, input int k);
        return (start / blk) * blk + ((start % blk) + k) % blk;
    endfunction

    // Classic single access; checks ack/err, latency, read data and the
    // following DONE cycle.
    task automatic classic(input logic w_en, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic exp_err, input int exp_lat);
        int          lat;
        int          word;
        bit          seen_ack;
        bit          seen_err;
        logic [31:0] base;
        base = use3 ? BASE3 : 32'h0;
        word = int'((a - base) >> 2);
        lat = -1; seen_ack = 0; seen_err = 0;
        @(negedge clk);
        addr = a; idata = d; sel = s; we = w_en; cti = CTI_CLASSIC; bte = BTE_LINEAR;
        cyc = 1'b1; stb = 1'b1;
        if (!w_en && !exp_err) exp_q.push_back(use3 ? model3[word] : model0[word]);
        for (int c = 0; c < 20; c++) begin
            #1;
            if (ack_m || err_m) begin
                lat = c; seen_ack = ack_m; seen_err = err_m;
                if (seen_ack && !w_en) begin
                    if (exp_q.size() > 0) chk("classic_rdata", odata_m, exp_q.pop_front());
                    else chk("classic_sb_empty", exp_q.size(), 1);
                end
                break;
            end
            @(negedge clk);
        end
        if (w_en && !exp_err) model_wr(word, d, s);
        chk("classic_lat", lat, exp_lat);
        chk("classic_ack", seen_ack, !exp_err);
        chk("classic_err", seen_err, exp_err);
        @(negedge clk);
        #1;
        chk("classic_done_quiet", ack_m | err_m, 0);
        chk("classic_done_st", st_m, 32'(ST_DONE));
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        $display("classic dut=%0d we=%0b addr=%h data=%h sel=%h lat=%0d ack=%0b err=%0b",
                 use3 ? 3 : 0, w_en, a, d, s, lat, seen_ack, seen_err);
    endtask

    // Incrementing burst on dut0; err_beat < 0 means every beat is acked.
    task automatic burst(input logic w_en, input int start, input int n, input logic [1:0] b,
                         input logic [31:0] dbase, input int err_beat);
        int blk, beat, w, acks, first_c, last_c;
        bit got_err, done, adv;
        blk = (b == BTE_WRAP4) ? 4 : (b == BTE_WRAP8) ? 8 : (b == BTE_WRAP16) ? 16 : DEPTH;
        beat = 0; acks = 0; first_c = -1; last_c = -1; got_err = 0; done = 0;
        @(negedge clk);
        w = beat_word(start, blk, 0);
        addr = 32'(w * 4); idata = dbase; sel = 4'hF; we = w_en; bte = b;
        cti = (n == 1) ? CTI_EOB : CTI_INCR; cyc = 1'b1; stb = 1'b1;
        if (!w_en && err_beat != 0) exp_q.push_back(model0[w]);
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            adv = 0;
            if (err_m) begin
                got_err = 1;
                chk("burst_err_beat", beat, err_beat);
                done = 1;
            end else if (ack_m) begin
                if (first_c < 0) first_c = c;
                last_c = c; acks++; adv = 1;
                if (w_en) model_wr(w, idata, sel);
                else if (exp_q.size() > 0) chk("burst_rdata", odata_m, exp_q.pop_front());
                else chk("burst_sb_empty", exp_q.size(), 1);
                beat++;
                if (beat == n) done = 1;
            end
            if (!done) begin
                @(negedge clk);
                if (adv) begin
                    w = beat_word(start, blk, beat);
                    addr = 32'(w * 4); idata = dbase + 32'(beat);
                    cti = (beat == n - 1) ? CTI_EOB : CTI_INCR;
                    if (!w_en && beat != err_beat) exp_q.push_back(model0[w]);
                end
            end
        end
        chk("burst_acks", acks, (err_beat < 0) ? n : err_beat);
        chk("burst_err_seen", got_err, err_beat >= 0);
        if (acks > 1) chk("burst_consec", last_c - first_c, acks - 1);
        @(negedge clk);
        #1;
        chk("burst_done_quiet", ack_m | err_m, 0);
        chk("burst_done_st", st_m, 32'(ST_DONE));
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC;
        $display("burst we=%0b start=%0d beats=%0d bte=%0d acks=%0d err=%0b",
                 w_en, start, n, b, acks, got_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ack", ack0, 0);
        chk("rst_err", err0, 0);
        chk("rst_rty", {rty0, rty3}, 0);
        chk("rst_odata", odata0 | odata3, 0);
        chk("rst_st", {st3, st0}, 32'(ST_IDLE));
        $display("reset released");
        @(negedge clk);
        rst = 1'b0;

        // Single write/read round trip.
        classic(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 1);
        classic(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 1);

        // Byte-lane merge and an all-lanes-disabled write.
        classic(1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 1'b0, 1);
        classic(1'b1, 32'h20, 32'h1122_3344, 4'b0101, 1'b0, 1);
        classic(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 1);
        chk("sel_merge_model", model0[8], 32'hFF22_FF44);
        classic(1'b1, 32'h20, 32'h0000_0000, 4'b0000, 1'b0, 1);
        classic(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 1);

        // Window end: error terminate, nothing written through an alias.
        for (int i = 0; i < 4; i++) classic(1'b1, 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 1'b0, 1);
        classic(1'b0, 32'(DEPTH * 4), 32'h0, 4'hF, 1'b1, 1);
        classic(1'b1, 32'(DEPTH * 4), 32'h5A5A_5A5A, 4'hF, 1'b1, 1);
        classic(1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1);

        // Wrap4 read from word 2, wrap8 write crossing its block, linear past the end.
        burst(1'b0, 2, 4, BTE_WRAP4, 32'h0, -1);
        burst(1'b1, 13, 5, BTE_WRAP8, 32'hC0DE_0000, -1);
        classic(1'b0, 32'(8 * 4), 32'h0, 4'hF, 1'b0, 1);
        classic(1'b0, 32'(13 * 4), 32'h0, 4'hF, 1'b0, 1);
        classic(1'b1, 32'(62 * 4), 32'h6262_6262, 4'hF, 1'b0, 1);
        classic(1'b1, 32'(63 * 4), 32'h6363_6363, 4'hF, 1'b0, 1);
        burst(1'b0, 62, 3, BTE_LINEAR, 32'h0, 2);

        // Reset during the second beat of a write burst.
        for (int i = 0; i < 4; i++) classic(1'b1, 32'(80 + 4 * i), 32'h0000_00A0 + 32'(i), 4'hF, 1'b0, 1);
        @(negedge clk);
        addr = 32'd80; idata = 32'h1111_0001; sel = 4'hF; we = 1'b1;
        cti = CTI_INCR; bte = BTE_LINEAR; cyc = 1'b1; stb = 1'b1;
        first_ack = 0;
        for (int c = 0; c < 10 && !first_ack; c++) begin
            #1;
            if (ack_m) first_ack = 1;
            else @(negedge clk);
        end
        chk("rstb_beat1_ack", first_ack, 1);
        model_wr(20, 32'h1111_0001, 4'hF);
        @(negedge clk);
        addr = 32'd84; idata = 32'h1111_0002; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC;
        #1;
        chk("rstb_ack", ack0, 0);
        chk("rstb_err", err0, 0);
        chk("rstb_odata", odata0, 0);
        chk("rstb_st", st0, 32'(ST_IDLE));
        $display("burst reset-abort at beat 2");
        for (int i = 0; i < 4; i++) classic(1'b0, 32'(80 + 4 * i), 32'h0, 4'hF, 1'b0, 1);

        // Three wait states on the second instance.
        @(negedge clk);
        use3 = 1'b1;
        classic(1'b1, BASE3 + 32'h20, 32'hCAFE_F00D, 4'hF, 1'b0, 4);
        classic(1'b0, BASE3 + 32'h20, 32'h0, 4'hF, 1'b0, 4);
        @(negedge clk);
        use3 = 1'b0;

        chk("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
